// File: rtl/teller_dispatcher.sv
// teller_dispatcher: round-robin dispatch of queued customers onto three bank tellers
// Ports: clk/rst (sync, active-high); teller_active[2:0] staffed tellers; queue_count waiting customers;
// dequeue/grant_valid one-cycle grant pulses; grant_id chosen teller; teller_busy per-teller service flags;
// free_tellers registered count of staffed idle tellers; served_count wrapping grant total.
module teller_dispatcher #(
    parameter int SERVICE_CYCLES = 8,
    parameter int QW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    teller_active,
    input  logic [QW-1:0] queue_count,
    output logic          dequeue,
    output logic          grant_valid,
    output logic [1:0]    grant_id,
    output logic [2:0]    teller_busy,
    output logic [1:0]    free_tellers,
    output logic [7:0]    served_count
);
    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;
    state_t state, state_nxt;
    logic [1:0] last, c1, c2, sel;
    logic [2:0] elig, busy_nxt, free_vec;
    logic decide;
    logic [7:0] timer [3];

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return x == 2'd2 ? 2'd0 : x + 2'd1;
    endfunction

    assign elig = teller_active & ~teller_busy;
    assign c1 = inc3(last);
    assign c2 = inc3(c1);
    assign sel = elig[c1] ? c1 : elig[c2] ? c2 : last;
    assign decide = state == IDLE && queue_count != '0 && elig != 3'b000;
    assign dequeue = state == GRANT;
    assign grant_valid = state == GRANT;
    // free count is taken from next-cycle busy so a grant shows up in the same cycle busy rises
    assign free_vec = teller_active & ~busy_nxt;

    always_comb begin
        state_nxt = state == GRANT ? HOLD : state == HOLD ? IDLE : decide ? GRANT : IDLE;
        busy_nxt = teller_busy;
        for (int i = 0; i < 3; i++)
            busy_nxt[i] = (decide && sel == 2'(i)) ? 1'b1 : (teller_busy[i] && timer[i] == 8'd1) ? 1'b0 : teller_busy[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last <= 2'd2;
            grant_id <= 2'd0;
            teller_busy <= 3'b000;
            free_tellers <= 2'd0;
            served_count <= 8'd0;
            for (int i = 0; i < 3; i++) timer[i] <= 8'd0;
        end else begin
            state <= state_nxt;
            teller_busy <= busy_nxt;
            free_tellers <= {1'b0, free_vec[0]} + {1'b0, free_vec[1]} + {1'b0, free_vec[2]};
            if (decide) begin
                last <= sel;
                grant_id <= sel;
                served_count <= served_count + 8'd1;
            end
            // timer is nonzero exactly while busy; reaching zero coincides with busy clearing
            for (int i = 0; i < 3; i++)
                timer[i] <= (decide && sel == 2'(i)) ? 8'(SERVICE_CYCLES) : timer[i] != 8'd0 ? timer[i] - 8'd1 : 8'd0;
        end
    end
endmodule
